// File: rtl/mux2_stream_pkg.sv
// Shared types and defaults for the 2:1 stream multiplexer.
package mux2_stream_pkg;

  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_state_e;

  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer moves past the
// granted requester whenever advance is pulsed.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  // After serving source 0 favour source 1, and vice versa.
  always_comb begin
    prio_d = prio_q;
    if (advance && (gnt != 2'b00)) begin
      prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mux2_stream_arb.sv
// Registered 2:1 valid/ready stream merge with round-robin arbitration.
// Define MUX2_STREAM_PKT_LOCK_EN for packet-atomic (last-delimited) grants.
module mux2_stream_arb
  import mux2_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  src_e              out_sel_q, out_sel_d;

  logic       load_en;
  logic       xfer;
  logic       xfer_last;
  logic       advance;
  logic [1:0] req;
  logic [1:0] gnt;

  assign load_en   = !out_valid_q || out_ready;
  assign xfer      = load_en && (gnt != 2'b00);
  assign xfer_last = gnt[1] ? in1_last : in0_last;

`ifdef MUX2_STREAM_PKT_LOCK_EN
  lock_state_e lock_q, lock_d;

  // While a packet is open only its owner may request; the other is masked.
  always_comb begin
    req = {in1_valid, in0_valid};
    case (lock_q)
      LOCK0:   req = {1'b0, in0_valid};
      LOCK1:   req = {in1_valid, 1'b0};
      default: req = {in1_valid, in0_valid};
    endcase
  end

  always_comb begin
    lock_d = lock_q;
    if (xfer) begin
      if (xfer_last) begin
        lock_d = UNLOCKED;
      end else begin
        lock_d = gnt[1] ? LOCK1 : LOCK0;
      end
    end
  end

  assign advance = xfer && xfer_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= UNLOCKED;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign req     = {in1_valid, in0_valid};
  assign advance = xfer;
`endif

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  assign in0_ready = load_en && gnt[0];
  assign in1_ready = load_en && gnt[1];

  // Payload holds on a bubble; only the valid flag drops.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = gnt[1] ? in1_data : in0_data;
        out_last_d = xfer_last;
        out_sel_d  = gnt[1] ? SRC1 : SRC0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= SRC0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux2_stream_arb.sv
// Self-checking bench for mux2_stream_arb: directed vector table, hand-written
// reset/lock sequences, and randomized traffic against a reference model.
module tb_mux2_stream_arb;

`ifdef MUX2_STREAM_PKT_LOCK_EN
  localparam bit LOCK_MODE = 1'b1;
`else
  localparam bit LOCK_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in0_valid = 1'b0, in0_ready, in0_last = 1'b0;
  logic [7:0] in0_data = 8'h00;
  logic       in1_valid = 1'b0, in1_ready, in1_last = 1'b0;
  logic [7:0] in1_data = 8'h00;
  logic       out_valid, out_ready = 1'b0, out_last, out_sel;
  logic [7:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux2_stream_arb #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_last = 1'b0; in1_last = 1'b0; in0_data = 8'h00; in1_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       ordy;
    logic       r0;
    logic       r1;
    logic       ov;
    logic [7:0] od;
    logic       ol;
    logic       os;
  } vec_t;

  vec_t tbl[17];

  // Expected handshake pattern for the lock sequence (per cycle).
  logic [3:0] lk_r0, lk_r1;

  // Reference model state
  int m_hold_v, m_hold_d, m_hold_l, m_hold_s, m_prio, m_lock;

  initial begin
    // inputs (v0,d0,v1,d1,out_ready) -> readies, then out register before the edge
    tbl[0]  = '{1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 8'h13, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 8'h5B, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h5B, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'h5B, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 8'h5B, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5B, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5B, 1'b1, 1'b0};

    // ---------------- directed vector table ----------------
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in0_valid = tbl[i].v0; in0_data = tbl[i].d0; in0_last = 1'b1;
      in1_valid = tbl[i].v1; in1_data = tbl[i].d1; in1_last = 1'b1;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in0_ready", i), 32'(in0_ready), 32'(tbl[i].r0));
      chk($sformatf("vec%0d_in1_ready", i), 32'(in1_ready), 32'(tbl[i].r1));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("vec%0d_out_last", i), 32'(out_last), 32'(tbl[i].ol));
      chk($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].os));
    end

    // ---------------- async reset mid-stream ----------------
    do_reset();
    @(negedge clk);
    in1_valid = 1'b1; in1_data = 8'hE7; in1_last = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in1_valid = 1'b0; in0_valid = 1'b1; in0_data = 8'hC3; in0_last = 1'b1;
    @(negedge clk);
    in0_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("arst_pre_valid", 32'(out_valid), 32'd1);
    chk("arst_pre_data", 32'(out_data), 32'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in0_valid = 1'b1; in0_data = 8'h01; in1_valid = 1'b1; in1_data = 8'h02; out_ready = 1'b1;
    #1;
    chk("arst_first_gnt_r0", 32'(in0_ready), 32'd1);
    chk("arst_first_gnt_r1", 32'(in1_ready), 32'd0);

    // ---------------- packet sequence (lock vs interleave) ----------------
    if (LOCK_MODE) begin
      lk_r1 = 4'b0111; lk_r0 = 4'b1000;   // bit k = cycle k
    end else begin
      lk_r1 = 4'b0101; lk_r0 = 4'b1010;
    end
    do_reset();
    @(negedge clk);
    in0_valid = 1'b1; in0_data = 8'h40; in0_last = 1'b1; in1_valid = 1'b0; out_ready = 1'b1;
    begin
      int p, n0;
      p = 0; n0 = 1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        in0_valid = 1'b1; in0_data = 8'(8'h40 + n0); in0_last = 1'b1;
        in1_valid = (p < 3); in1_data = 8'(8'h90 + p); in1_last = (p == 2);
        #1;
        chk($sformatf("pkt%0d_in0_ready", k), 32'(in0_ready), 32'(lk_r0[k]));
        chk($sformatf("pkt%0d_in1_ready", k), 32'(in1_ready), 32'(lk_r1[k]));
        if (k > 0) chk($sformatf("pkt%0d_out_sel", k), 32'(out_sel), 32'(lk_r1[k-1]));
        if (in1_ready) p++;
        if (in0_ready) n0++;
      end
    end

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    m_hold_v = 0; m_hold_d = 0; m_hold_l = 0; m_hold_s = 0; m_prio = 0; m_lock = 0;
    for (int c = 0; c < 400; c++) begin
      int e0, e1, g, load;
      @(negedge clk);
      in0_valid = ($urandom_range(3) != 0);
      in1_valid = ($urandom_range(3) != 0);
      in0_data  = 8'($urandom);
      in1_data  = 8'($urandom);
      in0_last  = ($urandom_range(2) == 0);
      in1_last  = ($urandom_range(2) == 0);
      out_ready = ($urandom_range(3) != 0);
      #1;
      e0 = (in0_valid && (m_lock == 0 || m_lock == 1)) ? 1 : 0;
      e1 = (in1_valid && (m_lock == 0 || m_lock == 2)) ? 1 : 0;
      if (e0 && e1) g = m_prio;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
      else          g = -1;
      load = (!m_hold_v || out_ready) ? 1 : 0;
      chk("rnd_in0_ready", 32'(in0_ready), (load && g == 0) ? 32'd1 : 32'd0);
      chk("rnd_in1_ready", 32'(in1_ready), (load && g == 1) ? 32'd1 : 32'd0);
      chk("rnd_out_valid", 32'(out_valid), 32'(m_hold_v));
      if (m_hold_v) begin
        chk("rnd_out_data", 32'(out_data), 32'(m_hold_d));
        chk("rnd_out_last", 32'(out_last), 32'(m_hold_l));
        chk("rnd_out_sel", 32'(out_sel), 32'(m_hold_s));
      end
      if (load) begin
        if (g >= 0) begin
          int lst;
          lst = (g == 0) ? int'(in0_last) : int'(in1_last);
          m_hold_v = 1;
          m_hold_d = (g == 0) ? int'(in0_data) : int'(in1_data);
          m_hold_l = lst;
          m_hold_s = g;
          if (!LOCK_MODE) begin
            m_prio = 1 - g;
          end else if (lst != 0) begin
            m_prio = 1 - g;
            m_lock = 0;
          end else begin
            m_lock = g + 1;
          end
        end else begin
          m_hold_v = 0;
        end
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
